// File: rtl/reg_bank.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, synchronous clear, optional hardwired-zero r0 and write bypass.
module reg_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter bit R0_ZERO  = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [WIDTH-1:0]  rdata_a_n,
    output logic              wr_err
);

    // One extra bit so NUM_REGS = 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic [WIDTH-1:0] mem_q [NUM_REGS];
    logic             wr_err_q, wr_err_d;
    logic             waddr_ok, wr_hit;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NREGS) && !(R0_ZERO && (addr == '0));
    endfunction

    assign waddr_ok = addr_ok(waddr);
    // A write that will really land this edge; bypass keys off the same condition.
    assign wr_hit   = we && !clr && waddr_ok;

    always_comb begin
        wr_err_d = wr_err_q;
        if (clr)
            wr_err_d = 1'b0;
        else if (we)
            wr_err_d = !waddr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem_q[i] <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr)
                    mem_q[i] <= '0;
                else if (wr_hit && (waddr == ADDR_W'(i)))
                    mem_q[i] <= wdata;
            end
            wr_err_q <= wr_err_d;
        end
    end

    function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr_ok(addr)) begin
            if (BYPASS && wr_hit && (addr == waddr))
                val = wdata;
            else
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr == ADDR_W'(i))
                        val = mem_q[i];
        end
        return val;
    endfunction

    assign rdata_a   = rd(raddr_a);
    assign rdata_b   = rd(raddr_b);
    assign rdata_a_n = ~rdata_a;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default build, a read-old build and a 6-deep build
// share one stimulus bus; each is checked against hand-computed values.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n, clr, we;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;

    logic [7:0] ra_a, rb_a, rn_a;  logic err_a;
    logic [7:0] ra_b, rb_b, rn_b;  logic err_b;
    logic [7:0] ra_c, rb_c, rn_c;  logic err_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .NUM_REGS(8), .ADDR_W(3), .R0_ZERO(1'b1), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra_a), .raddr_b(raddr_b), .rdata_b(rb_a),
        .rdata_a_n(rn_a), .wr_err(err_a));

    reg_bank #(.WIDTH(8), .NUM_REGS(8), .ADDR_W(3), .R0_ZERO(1'b1), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra_b), .raddr_b(raddr_b), .rdata_b(rb_b),
        .rdata_a_n(rn_b), .wr_err(err_b));

    reg_bank #(.WIDTH(8), .NUM_REGS(6), .ADDR_W(3), .R0_ZERO(1'b1), .BYPASS(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra_c), .raddr_b(raddr_b), .rdata_b(rb_c),
        .rdata_a_n(rn_c), .wr_err(err_c));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_err;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp_c [6];

    initial begin
        // Write, then read back with we dropped; checks the default build.
        vecs[0] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 8'h3C, 8'h3C, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 8'h77, 3'd0, 3'd5, 8'h00, 8'h3C, 1'b1};
        vecs[2] = '{1'b1, 3'd1, 8'h11, 3'd1, 3'd0, 8'h11, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 3'd7, 8'hFF, 3'd7, 3'd1, 8'hFF, 8'h11, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 8'hFF, 8'h3C, 1'b0};
        vecs[5] = '{1'b1, 3'd2, 8'h10, 3'd2, 3'd3, 8'h10, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 3'd0, 8'h01, 3'd2, 3'd0, 8'h10, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h10, 8'h10, 1'b1};
        vecs[8] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd2, 8'hA5, 8'h10, 1'b0};

        rst_n = 1'b0; clr = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; raddr_a = 3'd3; raddr_b = 3'd5;
        #12;
        chk("reset rdata_a", ra_a, 8'h00);
        chk("reset rdata_b", rb_a, 8'h00);
        chk("reset rdata_a_n", rn_a, 8'hFF);
        chk("reset wr_err", {7'd0, err_a}, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            @(posedge clk); #1 we = 1'b0; #1;
            chk($sformatf("vec%0d rdata_a", i), ra_a, vecs[i].exp_a);
            chk($sformatf("vec%0d rdata_b", i), rb_a, vecs[i].exp_b);
            chk($sformatf("vec%0d rdata_a_n", i), rn_a, ~vecs[i].exp_a);
            chk($sformatf("vec%0d wr_err", i), {7'd0, err_a}, {7'd0, vecs[i].exp_err});
        end

        // Same-cycle write to r2 (holding 0x10): write-first vs read-old.
        @(negedge clk);
        we = 1'b1; waddr = 3'd2; wdata = 8'h99; raddr_a = 3'd2; raddr_b = 3'd2;
        #1;
        chk("bypass rdata_b", rb_a, 8'h99);
        chk("bypass rdata_a_n", rn_a, 8'h66);
        chk("readold rdata_b pre", rb_b, 8'h10);
        @(posedge clk); #1;
        chk("readold rdata_b post", rb_b, 8'h99);

        // Illegal writes never bypass; 7 is legal for u_a but not for the 6-deep build.
        @(negedge clk);
        waddr = 3'd0; wdata = 8'h5A; raddr_a = 3'd0; #1;
        chk("no bypass to r0", ra_a, 8'h00);
        waddr = 3'd7; wdata = 8'hAB; raddr_a = 3'd7; raddr_b = 3'd6; #1;
        chk("bypass r7 8-deep", ra_a, 8'hAB);
        chk("no bypass r7 6-deep", ra_c, 8'h00);
        @(posedge clk); #1 we = 1'b0; #1;
        chk("6-deep wr_err", {7'd0, err_c}, 8'h01);
        chk("8-deep wr_err", {7'd0, err_a}, 8'h00);
        chk("6-deep read 7", ra_c, 8'h00);
        chk("6-deep read 6", rb_c, 8'h00);
        exp_c = '{8'h00, 8'h11, 8'h99, 8'hA5, 8'h00, 8'h3C};
        for (int i = 1; i < 6; i++) begin
            raddr_a = 3'(i); #1;
            chk($sformatf("6-deep r%0d", i), ra_c, exp_c[i]);
        end

        // clr beats a simultaneous write.
        @(negedge clk);
        we = 1'b1; waddr = 3'd4; wdata = 8'h55;
        @(posedge clk); #1 we = 1'b0; raddr_a = 3'd4; #1;
        chk("r4 written", ra_a, 8'h55);
        @(negedge clk);
        clr = 1'b1; we = 1'b1; waddr = 3'd6; wdata = 8'hEE; raddr_a = 3'd4; raddr_b = 3'd6; #1;
        chk("no bypass under clr", rb_a, 8'h00);
        @(posedge clk); #1 clr = 1'b0; we = 1'b0; #1;
        chk("clr r4", ra_a, 8'h00);
        chk("clr r6", rb_a, 8'h00);
        chk("clr 6-deep wr_err", {7'd0, err_c}, 8'h00);
        raddr_a = 3'd3; #1;
        chk("clr r3", ra_a, 8'h00);

        // Asynchronous reset mid-cycle, with wr_err set beforehand.
        @(negedge clk);
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        @(posedge clk); #1 waddr = 3'd0; wdata = 8'h77;
        @(posedge clk); #1 we = 1'b0; raddr_a = 3'd3; #1;
        chk("pre-reset r3", ra_a, 8'hA5);
        chk("pre-reset wr_err", {7'd0, err_a}, 8'h01);
        #2 rst_n = 1'b0; #1;
        chk("async rst rdata_a", ra_a, 8'h00);
        chk("async rst rdata_a_n", rn_a, 8'hFF);
        chk("async rst wr_err", {7'd0, err_a}, 8'h00);
        @(negedge clk);
        we = 1'b1; waddr = 3'd3; wdata = 8'hC3;
        @(posedge clk); #1 we = 1'b0; #1;
        chk("write during reset", ra_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h3C;
        @(posedge clk); #1 we = 1'b0; raddr_a = 3'd5; #1;
        chk("first write after reset", ra_a, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
